// File: rtl/stack_ctrl_if.sv
// stack_ctrl_if: request/response channel between the control unit and the
// stack sequencer. The control unit is the master and raises one-cycle
// requests. The sequencer is the slave and answers with busy/done/err and
// the popped bytes.
interface stack_ctrl_if;
  logic       req_valid;
  logic [2:0] req_op;
  logic [7:0] req_data;
  logic [7:0] req_aux;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] rd_data;
  logic [7:0] rd_aux;

  modport master (
    output req_valid, req_op, req_data, req_aux,
    input  busy, done, err, rd_data, rd_aux
  );

  modport slave (
    input  req_valid, req_op, req_data, req_aux,
    output busy, done, err, rd_data, rd_aux
  );
endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: sequencer for PUSH/POP/CALL/RET/LDSP.
// - Drives the stack pointer controls (rw/r0) and the data memory strobes.
// - Returns popped bytes to the control unit.
// - Reloads the pointer to 8'hFF after reset, because the pointer itself has
//   no reset.
//
// Optional feature macro: STACK_GUARD_EN.
// - Defined: overflow and underflow requests are rejected with done+err.
// - Undefined: every request proceeds, the pointer wraps, and depth counts
//   modulo 128.
//
// Every output comes from a register. The strobe registers load the decode
// of the next state, so they line up cycle-for-cycle with the state register.
module stack_ctrl #(
  parameter int DEPTH_MAX = 80
) (
  input  logic             clk,
  input  logic             rst_n,
  stack_ctrl_if.slave      req_if,
  output logic [1:0]       sp_rw_o,
  output logic [7:0]       sp_r0_o,
  output logic             mem_we_o,
  output logic             mem_re_o,
  output logic [7:0]       mem_wdata_o,
  input  logic [7:0]       mem_rdata_i,
  output logic [6:0]       depth_o
);

  // depth is a 7-bit counter, so the usable range must fit in it
  if (DEPTH_MAX < 2 || DEPTH_MAX > 127) begin : g_bad_depth
    $error("stack_ctrl: DEPTH_MAX must lie in 2..127");
  end

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_LDSP = 3'd5;

  localparam logic [1:0] RW_HOLD = 2'b00;
  localparam logic [1:0] RW_DEC  = 2'b01;
  localparam logic [1:0] RW_INC  = 2'b10;
  localparam logic [1:0] RW_LOAD = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_WR1  = 3'd2,
    ST_WR2  = 3'd3,
    ST_RD1  = 3'd4,
    ST_RD2  = 3'd5,
    ST_CAP  = 3'd6,
    ST_LD   = 3'd7
  } state_e;

  state_e     state_q, state_d;
  logic       armed_q;

  logic [2:0] op_q, op_d;
  logic [7:0] data_q, data_d;
  logic [7:0] aux_q, aux_d;

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic [7:0] rd_aux_q, rd_aux_d;
  logic [1:0] sp_rw_q, sp_rw_d;
  logic [7:0] sp_r0_q, sp_r0_d;
  logic       mem_we_q, mem_we_d;
  logic       mem_re_q, mem_re_d;
  logic [7:0] mem_wdata_q, mem_wdata_d;
  logic [6:0] depth_q, depth_d;

  logic       accept_s;
  logic       reject_s;

  // A request is seen only in IDLE. While the sequencer is busy, requests
  // are dropped and are not queued.
  assign accept_s = (state_q == ST_IDLE) && req_if.req_valid;

`ifdef STACK_GUARD_EN
  localparam logic [6:0] DEPTH_MAX_C = 7'(DEPTH_MAX);

  // Reject an operation that would overrun either end of the stack region
  always_comb begin
    reject_s = 1'b0;
    if (accept_s) begin
      case (req_if.req_op)
        OP_PUSH: reject_s = (depth_q >= DEPTH_MAX_C);
        OP_CALL: reject_s = (depth_q >= (DEPTH_MAX_C - 7'd1));
        OP_POP:  reject_s = (depth_q < 7'd1);
        OP_RET:  reject_s = (depth_q < 7'd2);
        OP_LDSP: reject_s = (req_if.req_data < 8'hAF);
        default: reject_s = 1'b0;
      endcase
    end else begin
      reject_s = 1'b0;
    end
  end
`else
  assign reject_s = 1'b0;
`endif

  // State register; armed_q keeps INIT visible for one full cycle after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: begin
        if (armed_q) state_d = ST_IDLE;
        else         state_d = ST_INIT;
      end
      ST_IDLE: begin
        if (accept_s && !reject_s) begin
          case (req_if.req_op)
            OP_PUSH, OP_CALL: state_d = ST_WR1;
            OP_POP,  OP_RET:  state_d = ST_RD1;
            OP_LDSP:          state_d = ST_LD;
            default:          state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      // CALL writes the return PC first, then the flags byte
      ST_WR1:  state_d = (op_q == OP_CALL) ? ST_WR2 : ST_IDLE;
      ST_WR2:  state_d = ST_IDLE;
      // RET needs a second read; POP goes straight to capture
      ST_RD1:  state_d = (op_q == OP_RET) ? ST_RD2 : ST_CAP;
      ST_RD2:  state_d = ST_CAP;
      ST_CAP:  state_d = ST_IDLE;
      ST_LD:   state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  // Latch the operation and its operands when a request is accepted
  always_comb begin
    op_d   = op_q;
    data_d = data_q;
    aux_d  = aux_q;
    if (accept_s) begin
      op_d   = req_if.req_op;
      data_d = req_if.req_data;
      aux_d  = req_if.req_aux;
    end else begin
      op_d   = op_q;
      data_d = data_q;
      aux_d  = aux_q;
    end
  end

  // Output decode: strobes for the state being entered, plus handshake flags
  always_comb begin
    sp_rw_d     = RW_HOLD;
    sp_r0_d     = 8'hFF;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_wdata_d = 8'h00;
    busy_d      = (state_d != ST_IDLE);
    // done marks the return to IDLE after an operation. A NOP or a rejected
    // request counts as an operation, even though the state stays in IDLE.
    done_d      = (state_d == ST_IDLE) && (state_q != ST_INIT) &&
                  ((state_q != ST_IDLE) || req_if.req_valid);
    err_d       = reject_s;
    case (state_d)
      ST_INIT: begin
        sp_rw_d = RW_LOAD;
        sp_r0_d = 8'hFF;
      end
      ST_WR1: begin
        sp_rw_d     = RW_DEC;
        mem_we_d    = 1'b1;
        mem_wdata_d = data_d;
      end
      ST_WR2: begin
        sp_rw_d     = RW_DEC;
        mem_we_d    = 1'b1;
        mem_wdata_d = aux_d;
      end
      ST_RD1, ST_RD2: begin
        sp_rw_d  = RW_INC;
        mem_re_d = 1'b1;
      end
      ST_LD: begin
        sp_rw_d = RW_LOAD;
        sp_r0_d = data_d;
      end
      default: begin
        sp_rw_d = RW_HOLD;
      end
    endcase
  end

  // Occupancy and read-back. These registers update at the end of each
  // action state, so both are settled in the done cycle.
  always_comb begin
    depth_d   = depth_q;
    rd_data_d = rd_data_q;
    rd_aux_d  = rd_aux_q;
    case (state_q)
      ST_INIT: depth_d = 7'd0;
      ST_WR1, ST_WR2: depth_d = depth_q + 7'd1;
      ST_RD1: depth_d = depth_q - 7'd1;
      ST_RD2: begin
        depth_d  = depth_q - 7'd1;
        rd_aux_d = mem_rdata_i;
      end
      ST_CAP: rd_data_d = mem_rdata_i;
      // (8'hFF - x) mod 128 equals (7'h7F - x[6:0]) mod 128
      ST_LD:  depth_d = 7'h7F - data_q[6:0];
      default: depth_d = depth_q;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= OP_NOP;
      data_q      <= 8'h00;
      aux_q       <= 8'h00;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_data_q   <= 8'h00;
      rd_aux_q    <= 8'h00;
      sp_rw_q     <= RW_HOLD;
      sp_r0_q     <= 8'hFF;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
      depth_q     <= 7'd0;
    end else begin
      op_q        <= op_d;
      data_q      <= data_d;
      aux_q       <= aux_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_data_q   <= rd_data_d;
      rd_aux_q    <= rd_aux_d;
      sp_rw_q     <= sp_rw_d;
      sp_r0_q     <= sp_r0_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_wdata_q <= mem_wdata_d;
      depth_q     <= depth_d;
    end
  end

  assign req_if.busy    = busy_q;
  assign req_if.done    = done_q;
  assign req_if.err     = err_q;
  assign req_if.rd_data = rd_data_q;
  assign req_if.rd_aux  = rd_aux_q;
  assign sp_rw_o        = sp_rw_q;
  assign sp_r0_o        = sp_r0_q;
  assign mem_we_o       = mem_we_q;
  assign mem_re_o       = mem_re_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign depth_o        = depth_q;

endmodule
